// File: rtl/ydma_run_sequencer.sv
// Host-side run controller for the ydma leaf: configures the leaf, pulses ap_start,
// waits for is_done, drains counter records to the host and reports completion/timeout.
`timescale 1ns/1ps
module ydma_run_sequencer #(
    parameter int unsigned AP_START_CYCLES = 4,
    parameter logic [31:0] TIMEOUT_CYCLES  = 32'hFFFF_FFFF,
    parameter int unsigned CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_output_size,
    input  logic [CNT_W-1:0] cmd_num_cnt,
    output logic [31:0]      output_size,
    output logic             output_size_valid,
    output logic [CNT_W-1:0] num_cnt_read,
    output logic             num_cnt_read_valid,
    output logic             ap_start,
    input  logic             is_done_valid,
    input  logic [63:0]      cnt,
    input  logic             cnt_vld,
    output logic             cnt_ack,
    output logic [63:0]      rec_data,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [CNT_W-1:0] rec_idx,
    output logic             busy,
    output logic             run_done,
    output logic             run_timeout,
    output logic [31:0]      run_cycles
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CFG   = 3'd1,
        START = 3'd2,
        RUN   = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [31:0]      size_q;
    logic [CNT_W-1:0] num_q;
    logic [31:0]      start_cnt;
    logic             timeout_hit;
    logic             handshake;

    assign output_size  = size_q;
    assign num_cnt_read = num_q;
    assign timeout_hit  = (TIMEOUT_CYCLES != 32'd0) && (run_cycles == TIMEOUT_CYCLES);

    // State register and run bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            size_q      <= '0;
            num_q       <= '0;
            start_cnt   <= '0;
            rec_idx     <= '0;
            run_cycles  <= '0;
            run_timeout <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        size_q      <= cmd_output_size;
                        num_q       <= cmd_num_cnt;
                        rec_idx     <= '0;
                        run_cycles  <= '0;
                        run_timeout <= 1'b0;
                    end
                end
                CFG:   start_cnt <= 32'(AP_START_CYCLES);
                START: start_cnt <= start_cnt - 32'd1;
                RUN, DRAIN: begin
                    if (run_cycles != '1) begin
                        run_cycles <= run_cycles + 32'd1;
                    end
                    if (timeout_hit) begin
                        run_timeout <= 1'b1;
                    end
                    if (handshake) begin
                        rec_idx <= rec_idx + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Next state and state-decoded outputs; DRAIN passes the cnt stream straight through
    always_comb begin
        state_next         = state;
        cmd_ready          = 1'b0;
        output_size_valid  = 1'b0;
        num_cnt_read_valid = 1'b0;
        ap_start           = 1'b0;
        cnt_ack            = 1'b0;
        rec_valid          = 1'b0;
        rec_data           = '0;
        run_done           = 1'b0;
        handshake          = 1'b0;
        busy               = (state != IDLE);
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    // the leaf never reports done for a zero-size run
                    state_next = (cmd_output_size == 32'd0) ? DONE : CFG;
                end
            end
            CFG: begin
                output_size_valid  = 1'b1;
                num_cnt_read_valid = 1'b1;
                state_next         = START;
            end
            START: begin
                ap_start = 1'b1;
                if (start_cnt == 32'd1) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (timeout_hit) begin
                    state_next = DONE;
                end else if (is_done_valid) begin
                    state_next = (num_q != '0) ? DRAIN : DONE;
                end
            end
            DRAIN: begin
                rec_data  = cnt;
                rec_valid = cnt_vld;
                cnt_ack   = cnt_vld & rec_ready;
                handshake = cnt_vld & rec_ready;
                if (timeout_hit) begin
                    state_next = DONE;
                end else if (handshake && (rec_idx == num_q - CNT_W'(1))) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                run_done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: doc/ydma_run_sequencer.md
Name: ydma_run_sequencer

Overview:
- Host-side run controller for the ydma leaf interface.
- Accepts one run command (output size, counter-read count), then configures the leaf in order: output_size, num_cnt_read, ap_start.
- Waits for the leaf's is_done indication, drains the expected number of 64-bit counter records from the leaf's cnt stream, and forwards them to the host record stream.
- Reports completion or timeout, plus total run cycles.

Parameters:
- AP_START_CYCLES, 4, cycles ap_start is held high per run (min 1).
- TIMEOUT_CYCLES, 32'hFFFF_FFFF, RUN+DRAIN cycle limit before abort; 0 disables timeout.
- CNT_W, 16, width of the counter-record count and of rec_idx.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- cmd_valid  in  1  run command valid
- cmd_ready  out  1  sequencer can accept a command
- cmd_output_size  in  32  output size, in 512-bit beats
- cmd_num_cnt  in  CNT_W  number of counter records expected
- output_size  out  32  to leaf; latched cmd_output_size
- output_size_valid  out  1  to leaf; 1-cycle pulse
- num_cnt_read  out  CNT_W  to leaf; latched cmd_num_cnt
- num_cnt_read_valid  out  1  to leaf; 1-cycle pulse
- ap_start  out  1  to leaf; level high for AP_START_CYCLES cycles
- is_done_valid  in  1  from leaf is_done_output_size_valid
- cnt  in  64  from leaf counter FIFO
- cnt_vld  in  1  from leaf
- cnt_ack  out  1  to leaf
- rec_data  out  64  record to host
- rec_valid  out  1  record valid
- rec_ready  in  1  host accepts record
- rec_idx  out  CNT_W  index of the current record (0-based)
- busy  out  1  state != IDLE
- run_done  out  1  1-cycle pulse at end of run
- run_timeout  out  1  sticky; last run aborted on timeout
- run_cycles  out  32  cycles spent in RUN+DRAIN for the last run

Behaviour:
- Clock clk; reset is synchronous, active-high.
- On reset: state=IDLE; all outputs 0 except cmd_ready=1; latched size/count, rec_idx, run_cycles and the start counter cleared.
- Reset mid-run aborts immediately: ap_start drops to 0 the next cycle and no run_done is emitted.
- States: IDLE, CFG, START, RUN, DRAIN, DONE.
- IDLE:
  - cmd_ready=1, ap_start=0.
  - On cmd_valid: latch size and count, clear run_timeout, run_cycles and rec_idx; go to CFG.
  - If cmd_output_size==0, go straight to DONE instead, since the leaf never signals done for size 0. No leaf config pulses are issued; run_done fires normally.
- CFG (1 cycle): output_size_valid=1 and num_cnt_read_valid=1 in the same cycle, driving the latched values; go to START.
- START:
  - ap_start=1 for exactly AP_START_CYCLES consecutive cycles, tracked by a down-counter.
  - Then ap_start=0 and go to RUN.
  - ap_start stays low at least 1 cycle between runs, guaranteed by the DONE and IDLE cycles.
- RUN:
  - run_cycles increments each cycle, saturating at all-ones.
  - On is_done_valid: go to DRAIN if the latched count > 0, else DONE.
  - is_done_valid is ignored in all other states.
- DRAIN:
  - rec_data=cnt, rec_valid=cnt_vld, cnt_ack=cnt_vld&rec_ready (combinational pass-through, no extra latency).
  - Each handshake increments rec_idx.
  - The handshake with rec_idx==count-1 goes to DONE.
  - run_cycles keeps incrementing.
  - Outside DRAIN: cnt_ack=0, rec_valid=0.
- Timeout: if TIMEOUT_CYCLES!=0 and run_cycles==TIMEOUT_CYCLES in RUN or DRAIN, set run_timeout=1 and go to DONE. Timeout takes priority over a same-cycle is_done_valid or final handshake.
- DONE (1 cycle): run_done=1, then go to IDLE.
- cmd_valid outside IDLE is ignored (cmd_ready=0).
- run_cycles and run_timeout hold until the next command is accepted.

Test Plan:
- Nominal run: cmd size=4, num_cnt=3 → CFG pulses carry 4 and 3; ap_start high 4 cycles; is_done_valid after 20 cycles → DRAIN; 3 records forwarded with rec_idx 0,1,2; run_done 1 cycle after the 3rd handshake; run_timeout=0; run_cycles matches the counted cycles.
- Backpressure: rec_ready toggles every other cycle with cnt_vld=1 → cnt_ack only when rec_ready=1; no record lost or duplicated; rec_data equals cnt on each handshake.
- Zero cases:
  - size=0 → IDLE→DONE→IDLE; no ap_start, no config pulses; run_done=1.
  - num_cnt=0, size=2 → run_done the cycle after is_done_valid, no DRAIN.
- Timeout: TIMEOUT_CYCLES=10, is_done_valid never asserted → run_timeout=1 and run_done at RUN cycle 10. Next cmd clears run_timeout and the next run completes.
- Reset mid-START (cycle 2 of ap_start) → ap_start=0 next cycle; busy=0, cmd_ready=1; no run_done. A subsequent command runs normally.
- cmd_valid held high while busy → only one run executes; a second run starts only after returning to IDLE.
